// File: rtl/time_of_day_bcd_counter.sv
// ---------------------------------------------------------------------------
// time_of_day_bcd_counter
//
// Keeps the time of day as six BCD digits (HH:MM:SS, 24-hour format). Time
// advances on each one-cycle SEC_PULSE from the upstream 1 Hz counter. A
// small set-mode FSM, driven by debounced button pulses, lets the user set
// the hour and then the minute.
//
// Ports:
//   TICK       in   1  system clock, rising edge
//   RESET_N    in   1  asynchronous active-low reset
//   Enable     in   1  global enable; low freezes all state
//   SEC_PULSE  in   1  one-TICK 1 Hz pulse
//   MODE_BTN   in   1  one-TICK mode-button pulse (RUN -> SET_HOUR -> SET_MIN)
//   INC_BTN    in   1  one-TICK increment-button pulse (set modes only)
//   HOUR_BCD   out  8  hours 00..23, [7:4] tens, [3:0] units
//   MIN_BCD    out  8  minutes 00..59
//   SEC_BCD    out  8  seconds 00..59
//   SET_STATE  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN
//   DAY_ROLL   out  1  one-TICK pulse on 23:59:59 -> 00:00:00 in RUN
// ---------------------------------------------------------------------------
module time_of_day_bcd_counter #(
    parameter logic [7:0] INIT_HOUR = 8'h12,
    parameter logic [7:0] INIT_MIN  = 8'h00
) (
    input  logic       TICK,
    input  logic       RESET_N,
    input  logic       Enable,
    input  logic       SEC_PULSE,
    input  logic       MODE_BTN,
    input  logic       INC_BTN,
    output logic [7:0] HOUR_BCD,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic [1:0] SET_STATE,
    output logic       DAY_ROLL
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } stateT;

    stateT      r_state;
    logic [3:0] r_hourTens, r_hourUnits;
    logic [3:0] r_minTens,  r_minUnits;
    logic [3:0] r_secTens,  r_secUnits;
    logic       r_dayRoll;

    // {carry, next value} for the incremented fields
    logic [8:0] w_secInc;
    logic [8:0] w_minInc;
    logic [8:0] w_hourInc;

    // Two-digit 00..59 increment. The >= compares make any out-of-range
    // digit walk back to a legal value instead of running away.
    function automatic logic [8:0] incSexa(input logic [3:0] tens, input logic [3:0] units);
        logic [8:0] res;
        if (units >= 4'd9) begin
            if (tens >= 4'd5)
                res = {1'b1, 8'h00};
            else
                res = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            res = {1'b0, tens, units + 4'd1};
        end
        return res;
    endfunction

    // Two-digit 00..23 increment; carry marks the 23 -> 00 wrap.
    function automatic logic [8:0] incHour(input logic [3:0] tens, input logic [3:0] units);
        logic [8:0] res;
        if ((tens >= 4'd2 && units >= 4'd3) || tens >= 4'd3)
            res = {1'b1, 8'h00};
        else if (units >= 4'd9)
            res = {1'b0, tens + 4'd1, 4'd0};
        else
            res = {1'b0, tens, units + 4'd1};
        return res;
    endfunction

    assign w_secInc  = incSexa(r_secTens,  r_secUnits);
    assign w_minInc  = incSexa(r_minTens,  r_minUnits);
    assign w_hourInc = incHour(r_hourTens, r_hourUnits);

    // Single registered FSM plus time digits. Enable low holds everything
    // except DAY_ROLL, which must read 0 on any edge that is not a rollover.
    always_ff @(posedge TICK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= RUN;
            r_hourTens  <= INIT_HOUR[7:4];
            r_hourUnits <= INIT_HOUR[3:0];
            r_minTens   <= INIT_MIN[7:4];
            r_minUnits  <= INIT_MIN[3:0];
            r_secTens   <= 4'd0;
            r_secUnits  <= 4'd0;
            r_dayRoll   <= 1'b0;
        end else if (Enable) begin
            r_dayRoll <= 1'b0;
            case (r_state)
                RUN: begin
                    // Seconds increment still applies when MODE arrives on the same edge
                    if (SEC_PULSE) begin
                        {r_secTens, r_secUnits} <= w_secInc[7:0];
                        if (w_secInc[8]) begin
                            {r_minTens, r_minUnits} <= w_minInc[7:0];
                            if (w_minInc[8]) begin
                                {r_hourTens, r_hourUnits} <= w_hourInc[7:0];
                                r_dayRoll <= w_hourInc[8];
                            end
                        end
                    end
                    if (MODE_BTN)
                        r_state <= SET_HOUR;
                end
                SET_HOUR: begin
                    // MODE beats INC; no carries or DAY_ROLL when setting
                    if (MODE_BTN)
                        r_state <= SET_MIN;
                    else if (INC_BTN)
                        {r_hourTens, r_hourUnits} <= w_hourInc[7:0];
                end
                SET_MIN: begin
                    // Leaving set mode restarts the minute at :00
                    if (MODE_BTN) begin
                        r_state    <= RUN;
                        r_secTens  <= 4'd0;
                        r_secUnits <= 4'd0;
                    end else if (INC_BTN) begin
                        {r_minTens, r_minUnits} <= w_minInc[7:0];
                    end
                end
                default: r_state <= RUN;
            endcase
        end else begin
            r_dayRoll <= 1'b0;
        end
    end

    assign HOUR_BCD  = {r_hourTens, r_hourUnits};
    assign MIN_BCD   = {r_minTens,  r_minUnits};
    assign SEC_BCD   = {r_secTens,  r_secUnits};
    assign SET_STATE = r_state;
    assign DAY_ROLL  = r_dayRoll;

endmodule

// File: doc/time_of_day_bcd_counter.md
Name: time_of_day_bcd_counter

Overview:
- Downstream of the 1 Hz modulo counter.
- Consumes its one-cycle digit-change pulse and keeps time of day as BCD hours, minutes and seconds in 24-hour format.
- Has a small set-mode FSM driven by pre-debounced single-cycle button pulses.
- BCD outputs feed the 7-segment display driver; DAY_ROLL is available for a future date counter.

Parameters:
- INIT_HOUR, 8'h12, BCD hour loaded on reset; legal range 00..23.
- INIT_MIN, 8'h00, BCD minute loaded on reset; legal range 00..59.

Ports:
- TICK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- Enable  in  1  global enable; when low, all state and outputs hold and every input pulse is ignored.
- SEC_PULSE  in  1  one-TICK-wide 1 Hz pulse from the upstream counter's Q_DIGIT_CHANGE.
- MODE_BTN  in  1  one-TICK-wide debounced mode-button pulse.
- INC_BTN  in  1  one-TICK-wide debounced increment-button pulse.
- HOUR_BCD  out  8  [7:4] tens, [3:0] units, 00..23.
- MIN_BCD  out  8  00..59.
- SEC_BCD  out  8  00..59.
- SET_STATE  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN; 11 is never driven.
- DAY_ROLL  out  1  one-TICK pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (async assert, sync use after release): HOUR_BCD=INIT_HOUR, MIN_BCD=INIT_MIN, SEC_BCD=00, SET_STATE=RUN, DAY_ROLL=0.
- Reset asserted mid-operation, including inside a set state: abandons everything immediately; no partial update survives.
- All outputs are registered. An input sampled high at edge k is reflected on the outputs after edge k (one-edge latency).
- Each BCD digit is held in its own 4-bit register. Binary counters with conversion are not used.
- Units roll 9->0 with carry into tens.
- Seconds and minutes: tens roll 5->0 at x9, i.e. 59->00 carries out.
- Hours: 23->00 wraps. Units roll 9->0 with tens+1 for 09->10 and 19->20.

FSM states and transitions:
- RUN:
  - SEC_PULSE=1 increments SEC_BCD.
  - 59->00 increments MIN_BCD; minute 59->00 increments HOUR_BCD.
  - 23:59:59 -> 00:00:00 also sets DAY_ROLL=1 for exactly one TICK.
  - MODE_BTN -> SET_HOUR.
  - INC_BTN is ignored.
- SET_HOUR:
  - SEC_PULSE is ignored, so time is frozen.
  - INC_BTN increments hour only: 23->00, no carry, no DAY_ROLL.
  - MODE_BTN -> SET_MIN.
- SET_MIN:
  - SEC_PULSE is ignored.
  - INC_BTN increments minute only: 59->00, no carry into hour.
  - MODE_BTN -> RUN, and on the same edge SEC_BCD clears to 00.

Simultaneous events:
- MODE_BTN and INC_BTN on the same edge: MODE wins; INC is dropped.
- MODE_BTN and SEC_PULSE on the same edge in RUN: the seconds increment (with any carries) is applied and the state moves to SET_HOUR on that edge.
- In SET_MIN, MODE_BTN and SEC_PULSE together: the seconds clear to 00 takes priority; the pulse is lost.
- Enable low overrides all of the above; DAY_ROLL is forced to 0 while Enable is low.

Other rules:
- DAY_ROLL is 0 on every edge that is not a RUN rollover.
- Inputs held high for several TICKs act as one event per edge. Edge detection is upstream's job.
- Illegal values are unreachable from reset. No recovery logic is required beyond the wrap rules; if out-of-range BCD is somehow present, the next increment must still terminate at a legal value via the wrap compare (>= limit -> 0).

Test Plan:
- Reset release, apply 61 SEC_PULSE in RUN -> 12:01:01; SET_STATE=00; DAY_ROLL never 1.
- Preload to 23:59:58 (via set mode plus pulses), apply 2 SEC_PULSE -> 23:59:59 then 00:00:00; DAY_ROLL high exactly one TICK, on the rollover edge.
- MODE, 13x INC, MODE, 61x INC, MODE -> SET_STATE 01, 10, 00 in turn; hour 12+13 wraps to 01; minute 00+61 wraps to 01 with no hour change; seconds 00 on exit; SEC_PULSEs issued during set leave SEC_BCD unchanged.
- Same-edge MODE_BTN+INC_BTN in SET_HOUR at hour 05 -> state moves to SET_MIN, hour stays 05.
- Enable=0 for 10 SEC_PULSE plus 3 MODE_BTN -> outputs and state unchanged; re-enable, 1 SEC_PULSE -> SEC_BCD+1.
- Assert RESET_N low asynchronously (between TICK edges) while in SET_MIN at 07:33 -> outputs immediately 12:00:00, state RUN, DAY_ROLL=0, before the next TICK edge.
